// File: rtl/box_draw_sequencer.sv
// box_draw_sequencer: walks every pixel of a BOX_W x BOX_H box from a latched
// top-left corner and presents x/y/colour/plot to a framebuffer write port
// that may stall with grant. Off-screen pixels are skipped without waiting.
// Optional build macro BOX_OUTLINE_EN: plot only the border pixels of the box.
module box_draw_sequencer #(
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned BOX_W    = 8,
  parameter int unsigned BOX_H    = 4,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                grant,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                shape_done
);

  localparam logic [X_W-1:0] DxLast = X_W'(BOX_W - 1);
  localparam logic [Y_W-1:0] DyLast = Y_W'(BOX_H - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDraw, StDone} state_e;

  state_e state_q, state_d;

  logic [X_W-1:0]      x0_q, x0_d, dx_q, dx_d, x_q, x_d;
  logic [Y_W-1:0]      y0_q, y0_d, dy_q, dy_d, y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  // Full-width sums so that overflow past the coordinate range is clipped, not wrapped.
  logic [X_W:0] x_sum;
  logic [Y_W:0] y_sum;
  logic         pix_visible;

  // Next walk position and state; abort overrides everything outside IDLE.
  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    colour_d = colour_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StLoad;
          x0_d     = x0;
          y0_d     = y0;
          colour_d = colour_in;
          dx_d     = '0;
          dy_d     = '0;
        end
      end
      StLoad: begin
        state_d = abort ? StIdle : StDraw;
      end
      StDraw: begin
        if (abort) begin
          state_d = StIdle;
        end else if (!plot_q || grant) begin
          // A clipped pixel (plot low) advances without waiting for grant.
          if (dx_q == DxLast) begin
            dx_d = '0;
            if (dy_q == DyLast) begin
              state_d = StDone;
            end else begin
              dy_d = dy_q + 1'b1;
            end
          end else begin
            dx_d = dx_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Address and visibility of the pixel that will be presented next cycle.
  always_comb begin
    x_sum       = {1'b0, x0_d} + {1'b0, dx_d};
    y_sum       = {1'b0, y0_d} + {1'b0, dy_d};
    pix_visible = (32'(x_sum) < SCREEN_W) && (32'(y_sum) < SCREEN_H);
`ifdef BOX_OUTLINE_EN
    pix_visible = pix_visible &&
                  ((dx_d == '0) || (dx_d == DxLast) || (dy_d == '0) || (dy_d == DyLast));
`else
    pix_visible = pix_visible;
`endif
  end

  // Registered output values; x/y hold their last value outside DRAW.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    plot_d = 1'b0;
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    if (state_d == StDraw) begin
      x_d    = x_sum[X_W-1:0];
      y_d    = y_sum[Y_W-1:0];
      plot_d = pix_visible;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      x0_q     <= '0;
      y0_q     <= '0;
      colour_q <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      colour_q <= colour_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  // An abort arriving in the DONE cycle itself must still cancel the completion pulse.
  assign shape_done = done_q & ~abort;

endmodule

// File: tb/tb_box_draw_sequencer.sv
// Self-checking bench for box_draw_sequencer: table-driven boxes, hand-written
// abort/ignored-start/async-reset sequences and randomized boxes checked
// cycle by cycle against a raster-index reference model.
module tb_box_draw_sequencer;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int BOX_W    = 8;
  localparam int BOX_H    = 4;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int NPIX     = BOX_W * BOX_H;

`ifdef BOX_OUTLINE_EN
  localparam int FullBoxPlots = 20;
  localparam int ClipPlots    = 5;
`else
  localparam int FullBoxPlots = 32;
  localparam int ClipPlots    = 8;
`endif

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [X_W-1:0]      x0 = '0;
  logic [Y_W-1:0]      y0 = '0;
  logic [COLOUR_W-1:0] colour_in = '0;
  logic                grant = 1'b0;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot, busy, shape_done;

  int n_cmp  = 0;
  int n_fail = 0;

  box_draw_sequencer #(
    .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W), .BOX_W(BOX_W), .BOX_H(BOX_H),
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .x0(x0), .y0(y0),
    .colour_in(colour_in), .grant(grant), .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .shape_done(shape_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int bx, by, bc, mode, stall_idx, stall_len, exp_plots, exp_done;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: pixel i of the raster walk is (i % BOX_W, i / BOX_W) from the corner.
  function automatic bit vis(input int bx, input int by, input int i);
    int dx = i % BOX_W;
    int dy = i / BOX_W;
    bit v  = ((bx + dx) < SCREEN_W) && ((by + dy) < SCREEN_H);
`ifdef BOX_OUTLINE_EN
    v = v && (dx == 0 || dx == BOX_W - 1 || dy == 0 || dy == BOX_H - 1);
`endif
    return v;
  endfunction

  function automatic int vis_count(input int bx, input int by);
    int n = 0;
    for (int i = 0; i < NPIX; i++) if (vis(bx, by, i)) n++;
    return n;
  endfunction

  // Called #1 after an edge; start is high for one cycle.
  task automatic start_only(input int bx, input int by, input int bc);
    start = 1'b1; x0 = X_W'(bx); y0 = Y_W'(by); colour_in = COLOUR_W'(bc);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // mode 0: grant tied high; 1: random grant; 2: grant only on visible pixels.
  task automatic run_box(input int bx, input int by, input int bc, input int mode,
                         input int stall_idx, input int stall_len,
                         output int plots, output int done_cyc);
    int  i = 0, c = 1, stalled = 0;
    bit  v, g, finished = 0;
    plots = 0; done_cyc = -1;
    grant = 1'b0;
    start_only(bx, by, bc);
    check("load_busy", busy, 1);
    check("load_plot", plot, 0);
    for (int guard = 0; guard < 400 && !finished; guard++) begin
      @(posedge clock); #1; c++;
      if (i < NPIX) begin
        v = vis(bx, by, i);
        check("plot", plot, v);
        check("x", x, (bx + i % BOX_W) % (1 << X_W));
        check("y", y, (by + i / BOX_W) % (1 << Y_W));
        check("busy_draw", busy, 1);
        check("early_done", shape_done, 0);
        if (v) check("colour", colour, bc);
        case (mode)
          0: g = 1'b1;
          1: g = ($urandom_range(0, 2) != 0);
          default: g = v;
        endcase
        if (i == stall_idx && stalled < stall_len) begin
          g = 1'b0;
          stalled++;
        end
        grant = g;
        if (plot && g) plots++;
        if (!v || g) i++;
      end else begin
        check("shape_done", shape_done, 1);
        check("done_plot", plot, 0);
        check("done_busy", busy, 1);
        if (shape_done) done_cyc = c;
        grant = 1'b0;
        finished = 1;
      end
    end
    if (!finished) check("timeout", 0, 1);
    @(posedge clock); #1;
    check("post_busy", busy, 0);
    check("post_done", shape_done, 0);
  endtask

  initial begin
    vec_t vecs[7];
    int   plots, done_cyc, ndone;

    vecs[0] = '{10, 20, 5, 0, -1, 0, FullBoxPlots, 34};
    vecs[1] = '{10, 20, 5, 0, 10, 3, FullBoxPlots, 37};  // stall at (12,21)
    vecs[2] = '{156, 118, 3, 2, -1, 0, ClipPlots, 34};
    vecs[3] = '{0, 0, 7, 0, -1, 0, FullBoxPlots, 34};
    vecs[4] = '{250, 125, 1, 0, -1, 0, 0, 34};
    vecs[5] = '{159, 119, 6, 2, -1, 0, 1, 34};
    vecs[6] = '{152, 0, 2, 0, -1, 0, FullBoxPlots, 34};

    // Reset state
    #12;
    check("rst_x", x, 0); check("rst_y", y, 0); check("rst_colour", colour, 0);
    check("rst_plot", plot, 0); check("rst_busy", busy, 0); check("rst_done", shape_done, 0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    check("idle_busy", busy, 0);

    // Table-driven boxes, back to back (start one cycle after shape_done)
    for (int k = 0; k < 7; k++) begin
      run_box(vecs[k].bx, vecs[k].by, vecs[k].bc, vecs[k].mode, vecs[k].stall_idx,
              vecs[k].stall_len, plots, done_cyc);
      check($sformatf("vec%0d_plots", k), plots, vecs[k].exp_plots);
      check($sformatf("vec%0d_done_cycle", k), done_cyc, vecs[k].exp_done);
    end

    // Abort in DRAW at pixel 5, then restart from (0,0)
    grant = 1'b1;
    start_only(10, 20, 5);
    repeat (6) @(posedge clock);
    #1;
    check("abort_at_px5_x", x, 15);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort_plot", plot, 0); check("abort_busy", busy, 0); check("abort_done", shape_done, 0);
    @(posedge clock); #1;
    check("abort_idle_done", shape_done, 0);
    run_box(0, 0, 4, 0, -1, 0, plots, done_cyc);
    check("restart_plots", plots, FullBoxPlots);
    check("restart_done_cycle", done_cyc, 34);

    // start+abort in IDLE: start wins; abort held into LOAD cancels
    abort = 1'b1;
    start_only(30, 30, 1);
    check("start_beats_abort", busy, 1);
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort_load_busy", busy, 0);
    check("abort_load_plot", plot, 0);

    // Abort in DONE suppresses shape_done
    grant = 1'b1;
    start_only(10, 20, 5);
    repeat (33) @(posedge clock);
    #1;
    abort = 1'b1;
    #1;
    check("abort_done_busy", busy, 1);
    check("abort_done_suppress", shape_done, 0);
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort_done_idle", busy, 0);
    check("abort_done_after", shape_done, 0);

    // start pulses in DRAW and in the DONE cycle are ignored
    ndone = 0;
    grant = 1'b1;
    start_only(10, 20, 5);
    for (int cyc = 2; cyc <= 40; cyc++) begin
      @(posedge clock); #1;
      if (shape_done) ndone++;
      if (cyc == 34) check("done_cycle_34", shape_done, 1);
      if (cyc == 35 || cyc == 36) check($sformatf("ignored_start_busy_c%0d", cyc), busy, 0);
      start = (cyc == 10 || cyc == 34);
    end
    start = 1'b0;
    check("single_shape_done", ndone, 1);

    // Async reset mid-DRAW clears outputs before the next edge
    start_only(20, 10, 6);
    repeat (8) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_plot", plot, 0); check("async_busy", busy, 0); check("async_x", x, 0);
    check("async_y", y, 0); check("async_colour", colour, 0); check("async_done", shape_done, 0);
    @(negedge clock); reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (shape_done || busy) ndone++;
    end
    check("no_done_after_reset", ndone, 0);

    // Randomized boxes against the model
    for (int r = 0; r < 24; r++) begin
      int bx = ($urandom_range(0, 1) != 0) ? $urandom_range(140, 255) : $urandom_range(0, 255);
      int by = ($urandom_range(0, 1) != 0) ? $urandom_range(110, 127) : $urandom_range(0, 127);
      int bc = $urandom_range(0, 7);
      int gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clock); #1;
        check("gap_busy", busy, 0);
        check("gap_plot", plot, 0);
      end
      run_box(bx, by, bc, 1, -1, 0, plots, done_cyc);
      check($sformatf("rand%0d_plots", r), plots, vis_count(bx, by));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/box_draw_sequencer.md
Name: box_draw_sequencer

Overview:
Sequences the pixel-write datapath for one note box on the game grid. The display FSM pulses start after it loads the box start coordinate. The block then walks every pixel of a BOX_W x BOX_H rectangle and presents x/y/colour/plot to the framebuffer write port, honouring a grant stall from that port. It pulses shape_done when the box is complete, which is the shapeDone input of the display FSM.

Parameters:
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
COLOUR_W, 3, colour width
BOX_W, 8, box width in pixels (1..2^X_W-1)
BOX_H, 4, box height in pixels (1..2^Y_W-1)
SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped
SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are clipped

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request; sampled only in IDLE
abort  in  1  synchronous cancel; returns to IDLE with no shape_done
x0  in  X_W  box top-left x; latched on accepted start
y0  in  Y_W  box top-left y; latched on accepted start
colour_in  in  COLOUR_W  fill colour; latched on accepted start
grant  in  1  framebuffer write port accepts the pixel this cycle
x  out  X_W  current pixel x
y  out  Y_W  current pixel y
colour  out  COLOUR_W  latched colour
plot  out  1  write request for the current pixel
busy  out  1  high in LOAD, DRAW and DONE
shape_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async): state=IDLE. x, y, colour, plot, busy, shape_done, dx and dy all 0.
- States: IDLE, LOAD, DRAW, DONE.
- IDLE: start=1 latches x0/y0/colour_in, clears dx/dy and goes to LOAD. start=0 stays in IDLE.
- LOAD: one cycle; registers the first pixel address; goes to DRAW. plot=0.
- DRAW: x = x0_l + dx and y = y0_l + dy, both registered outputs.
  - Sums are computed at X_W+1 and Y_W+1 bits.
  - Pixel is on-screen when the full-width sum is < SCREEN_W and < SCREEN_H. No wrap-around; overflow counts as clipped.
  - On-screen pixel: plot=1 and held stable until grant=1. Pixel advances in the cycle grant=1 is sampled.
  - Clipped pixel: plot=0 and it advances next cycle without waiting for grant.
  - grant while plot=0 is ignored.
- Advance order: dx increments. At dx=BOX_W-1, dx goes to 0 and dy increments (raster order).
- Last pixel is dx=BOX_W-1, dy=BOX_H-1. Once it is accepted or clipped, go to DONE.
- Minimum latency with grant tied high, start to shape_done: 2 + BOX_W*BOX_H cycles.
- DONE: shape_done=1 for exactly one cycle, plot=0, then IDLE. busy falls in the same edge as shape_done.
- start while busy: ignored, not queued.
- start in the same cycle as DONE: ignored. A new start is accepted one cycle after the shape_done cycle.
- abort: highest priority in LOAD, DRAW and DONE. Next cycle is IDLE with plot=0 and busy=0.
  - abort in DONE suppresses shape_done.
  - abort in IDLE has no effect. abort and start together in IDLE: start wins.
- Reset mid-DRAW: plot drops immediately (async); no shape_done.
- colour output holds its latched value in IDLE, which is harmless because plot=0.

Optional Feature:
BOX_OUTLINE_EN
- Defined: only border pixels are plotted (dx=0, dx=BOX_W-1, dy=0 or dy=BOX_H-1).
  - Interior pixels are treated as clipped: plot=0 and advance in one cycle.
  - Walk order and shape_done timing are otherwise unchanged.
- Undefined: every pixel of the rectangle is plotted (solid fill).

Test Plan:
1. Basic fill: x0=10, y0=20, BOX_W=8, BOX_H=4, grant=1, colour=3'b101 -> 32 plots in raster order (10,20)..(17,20)..(17,23), all colour 5; shape_done at cycle 34 after start; busy high cycles 1..34.
2. Stall: as test 1 with grant low for 3 cycles at pixel (12,21) -> x/y/plot held for those 3 cycles, no skipped or duplicated pixel; shape_done delayed by exactly 3 cycles.
3. Clipping: x0=156, y0=118 -> only x in 156..159 and y in 118..119 plotted (8 plots); the other 24 pixels show plot=0; shape_done at cycle 34 even with grant=0 on those clipped cycles.
4. Abort and restart: abort in DRAW at pixel 5 -> IDLE next cycle, plot=0, no shape_done. start one cycle later with x0=0, y0=0 -> full box drawn from (0,0).
5. Ignored start and async reset: start pulses in DRAW and in the DONE cycle -> no second box, exactly one shape_done. Async reset mid-DRAW -> all outputs 0 before the next clock edge.
6. BOX_OUTLINE_EN defined, 8x4 box at (0,0) -> 20 plots (rows 0 and 3 full, columns 0 and 7 on rows 1 and 2); shape_done still at cycle 34.
